// File: rtl/vga_pkg.sv
// Default VGA mode (800x600 @ 60 Hz, 40 MHz pixel clock) and vga_if field widths.
package vga_pkg;
   localparam int HOR_ACTIVE = 800;
   localparam int HOR_FP     = 40;
   localparam int HOR_SYNC   = 128;
   localparam int HOR_BP     = 88;
   localparam int HOR_TOTAL  = HOR_ACTIVE + HOR_FP + HOR_SYNC + HOR_BP;

   localparam int VER_ACTIVE = 600;
   localparam int VER_FP     = 1;
   localparam int VER_SYNC   = 4;
   localparam int VER_BP     = 23;
   localparam int VER_TOTAL  = VER_ACTIVE + VER_FP + VER_SYNC + VER_BP;

   localparam int FCNT_W     = 16;
   localparam int CNT_W      = 11;
   localparam int RGB_W      = 12;
endpackage

// File: rtl/vga_if.sv
// Display pipeline stream: pixel position, sync/blank timing and colour for one pixel per clock.
interface vga_if;
   import vga_pkg::*;

   logic [CNT_W-1:0] hcount;
   logic [CNT_W-1:0] vcount;
   logic             hsync;
   logic             vsync;
   logic             hblnk;
   logic             vblnk;
   logic [RGB_W-1:0] rgb;

   modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
   modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_timing_gen.sv
// VGA timing source: counters, active-high sync, blanking, line/frame strobes and frame count.
// All outputs registered (1 clk from en); en = 0 freezes the pixel and silences the strobes.
module vga_timing_gen #(
   parameter int HOR_ACTIVE = vga_pkg::HOR_ACTIVE,
   parameter int HOR_FP     = vga_pkg::HOR_FP,
   parameter int HOR_SYNC   = vga_pkg::HOR_SYNC,
   parameter int HOR_BP     = vga_pkg::HOR_BP,
   parameter int VER_ACTIVE = vga_pkg::VER_ACTIVE,
   parameter int VER_FP     = vga_pkg::VER_FP,
   parameter int VER_SYNC   = vga_pkg::VER_SYNC,
   parameter int VER_BP     = vga_pkg::VER_BP,
   parameter int FCNT_W     = vga_pkg::FCNT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   vga_if.out                vga_out,
   output logic              line_start,
   output logic              frame_start,
   output logic [FCNT_W-1:0] frame_cnt
);
   import vga_pkg::*;

   localparam int HT = HOR_ACTIVE + HOR_FP + HOR_SYNC + HOR_BP;
   localparam int VT = VER_ACTIVE + VER_FP + VER_SYNC + VER_BP;

   generate
      if (HT > 2048 || VT > 2048) begin : g_bad_mode
         $error("vga_timing_gen: mode totals do not fit 11-bit counters");
      end
   endgenerate

   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(HT - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(VT - 1);
   localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(HOR_ACTIVE);
   localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(HOR_ACTIVE + HOR_FP);
   localparam logic [CNT_W-1:0] HS_END   = CNT_W'(HOR_ACTIVE + HOR_FP + HOR_SYNC);
   localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(VER_ACTIVE);
   localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(VER_ACTIVE + VER_FP);
   localparam logic [CNT_W-1:0] VS_END   = CNT_W'(VER_ACTIVE + VER_FP + VER_SYNC);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [CNT_W-1:0]  hcount_q, hcount_d;
   logic [CNT_W-1:0]  vcount_q, vcount_d;
   logic              hsync_q, hsync_d;
   logic              vsync_q, vsync_d;
   logic              hblnk_q, hblnk_d;
   logic              vblnk_q, vblnk_d;
   logic              line_start_q, line_start_d;
   logic              frame_start_q, frame_start_d;
   logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic [CNT_W-1:0]  h_nxt, v_nxt;

   // Decode on the next counter values so every registered field describes the same pixel.
   always_comb begin
      h_nxt         = hcount_q;
      v_nxt         = vcount_q;
      hcount_d      = hcount_q;
      vcount_d      = vcount_q;
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      hblnk_d       = hblnk_q;
      vblnk_d       = vblnk_q;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
      frame_cnt_d   = frame_cnt_q;
      if (en) begin
         h_nxt = (hcount_q == H_LAST) ? '0 : hcount_q + CNT_ONE;
         if (hcount_q == H_LAST) begin
            v_nxt = (vcount_q == V_LAST) ? '0 : vcount_q + CNT_ONE;
         end
         hcount_d      = h_nxt;
         vcount_d      = v_nxt;
         hblnk_d       = (h_nxt >= H_ACT);
         hsync_d       = (h_nxt >= HS_BEG) && (h_nxt < HS_END);
         vblnk_d       = (v_nxt >= V_ACT);
         vsync_d       = (v_nxt >= VS_BEG) && (v_nxt < VS_END);
         line_start_d  = (h_nxt == '0);
         frame_start_d = (h_nxt == '0) && (v_nxt == '0);
         frame_cnt_d   = frame_cnt_q + FCNT_W'(frame_start_d);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hcount_q      <= '0;
         vcount_q      <= '0;
         hsync_q       <= 1'b0;
         vsync_q       <= 1'b0;
         hblnk_q       <= 1'b0;
         vblnk_q       <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         frame_cnt_q   <= '0;
      end else begin
         hcount_q      <= hcount_d;
         vcount_q      <= vcount_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         hblnk_q       <= hblnk_d;
         vblnk_q       <= vblnk_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         frame_cnt_q   <= frame_cnt_d;
      end
   end

   assign vga_out.hcount = hcount_q;
   assign vga_out.vcount = vcount_q;
   assign vga_out.hsync  = hsync_q;
   assign vga_out.vsync  = vsync_q;
   assign vga_out.hblnk  = hblnk_q;
   assign vga_out.vblnk  = vblnk_q;
   assign vga_out.rgb    = '0;
   assign line_start     = line_start_q;
   assign frame_start    = frame_start_q;
   assign frame_cnt      = frame_cnt_q;

endmodule
